// File: rtl/gate_level_bit_reg.sv
// Single-bit output stage: a register with synchronous active-high clear,
// or a plain wire when REGISTER_OUTPUTS is 0.
module gate_level_bit_reg #(
    parameter bit REGISTER_OUTPUTS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (REGISTER_OUTPUTS) begin : g_reg
            logic r_q;

            // Capture d each rising edge; rst clears to 0 at the edge only
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= d;
                end
            end

            assign q = r_q;
        end else begin : g_bypass
            // clk/rst have no role in the bypass path
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign q        = d;
        end
    endgenerate

endmodule

// File: rtl/gate_level.sv
// Seven two-input logic functions built from gate primitives, each driven
// through an optional one-cycle output stage.
module gate_level #(
    parameter bit REGISTER_OUTPUTS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic and_out,
    output logic or_out,
    output logic notb_out,
    output logic nand_out,
    output logic nor_out,
    output logic xor_out,
    output logic xnor_out
);

    wire w_and;
    wire w_or;
    wire w_notb;
    wire w_nand;
    wire w_nor;
    wire w_xor;
    wire w_xnor;

    // Gate network; X/Z on inputs propagates with primitive semantics
    and  u_and  (w_and,  a, b);
    or   u_or   (w_or,   a, b);
    not  u_notb (w_notb, b);
    nand u_nand (w_nand, a, b);
    nor  u_nor  (w_nor,  a, b);
    xor  u_xor  (w_xor,  a, b);
    xnor u_xnor (w_xnor, a, b);

    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_and_reg (
        .clk(clk), .rst(rst), .d(w_and),  .q(and_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_or_reg (
        .clk(clk), .rst(rst), .d(w_or),   .q(or_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_notb_reg (
        .clk(clk), .rst(rst), .d(w_notb), .q(notb_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_nand_reg (
        .clk(clk), .rst(rst), .d(w_nand), .q(nand_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_nor_reg (
        .clk(clk), .rst(rst), .d(w_nor),  .q(nor_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_xor_reg (
        .clk(clk), .rst(rst), .d(w_xor),  .q(xor_out)
    );
    gate_level_bit_reg #(.REGISTER_OUTPUTS(REGISTER_OUTPUTS)) u_xnor_reg (
        .clk(clk), .rst(rst), .d(w_xnor), .q(xnor_out)
    );

endmodule

// File: tb/tb_gate_level.sv
// Directed bench for gate_level: registered instance plus a combinational one.
module tb_gate_level;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic and_r, or_r, notb_r, nand_r, nor_r, xor_r, xnor_r;

    logic clk_c;
    logic rst_c;
    logic a_c;
    logic b_c;
    logic and_c, or_c, notb_c, nand_c, nor_c, xor_c, xnor_c;

    int n_total;
    int n_pass;

    // Hand-computed rows, packed {and,or,notb,nand,nor,xor,xnor}
    localparam logic [6:0] ROW_00 = 7'b0011101;
    localparam logic [6:0] ROW_01 = 7'b0101010;
    localparam logic [6:0] ROW_10 = 7'b0111010;
    localparam logic [6:0] ROW_11 = 7'b1100001;
    localparam logic [6:0] ZEROS  = 7'b0000000;

    gate_level #(.REGISTER_OUTPUTS(1'b1)) u_dut_reg (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .and_out(and_r), .or_out(or_r), .notb_out(notb_r), .nand_out(nand_r),
        .nor_out(nor_r), .xor_out(xor_r), .xnor_out(xnor_r)
    );

    gate_level #(.REGISTER_OUTPUTS(1'b0)) u_dut_comb (
        .clk(clk_c), .rst(rst_c), .a(a_c), .b(b_c),
        .and_out(and_c), .or_out(or_c), .notb_out(notb_c), .nand_out(nand_c),
        .nor_out(nor_c), .xor_out(xor_c), .xnor_out(xnor_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs_reg();
        return {and_r, or_r, notb_r, nand_r, nor_r, xor_r, xnor_r};
    endfunction

    function automatic logic [6:0] obs_comb();
        return {and_c, or_c, notb_c, nand_c, nor_c, xor_c, xnor_c};
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  vec_ab [5];
        logic [6:0]  vec_ex [5];
        logic [6:0]  prev;
        logic [1:0]  sw_ab [4];
        logic [6:0]  sw_ex [4];

        n_total = 0;
        n_pass  = 0;

        vec_ab = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        vec_ex = '{ROW_00, ROW_01, ROW_10, ROW_11, ROW_00};
        sw_ab  = '{2'b00, 2'b01, 2'b10, 2'b11};
        sw_ex  = '{ROW_00, ROW_01, ROW_10, ROW_11};

        clk_c = 1'b0;
        rst_c = 1'b1;
        a_c   = 1'b0;
        b_c   = 1'b0;

        // Reset held two edges with a=b=1
        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        tick();
        tick();
        check("reset_all_zero", obs_reg(), ZEROS);

        // Sweep rows; outputs lag inputs by one edge
        rst  = 1'b0;
        prev = ZEROS;
        for (int i = 0; i < 5; i++) begin
            {a, b} = vec_ab[i];
            #1;
            check($sformatf("lag_before_edge_%0d", i), obs_reg(), prev);
            tick();
            check($sformatf("row_after_edge_%0d", i), obs_reg(), vec_ex[i]);
            prev = vec_ex[i];
        end

        // Mid-cycle glitch on b must not reach registered outputs
        a = 1'b1;
        b = 1'b0;
        tick();
        check("hold_setup_10", obs_reg(), ROW_10);
        #2 b = 1'b1;
        #1;
        check("hold_mid_glitch", obs_reg(), ROW_10);
        #2 b = 1'b0;
        tick();
        check("hold_after_edge", obs_reg(), ROW_10);

        // Reset mid-operation is synchronous
        a = 1'b0;
        b = 1'b0;
        tick();
        check("pre_reset_00", obs_reg(), ROW_00);
        rst = 1'b1;
        #2;
        check("reset_not_async", obs_reg(), ROW_00);
        tick();
        check("reset_one_edge", obs_reg(), ZEROS);
        rst = 1'b0;
        tick();
        check("post_reset_00", obs_reg(), ROW_00);

        // Reset release loads current inputs on the first edge
        rst = 1'b1;
        tick();
        a = 1'b1;
        b = 1'b1;
        rst = 1'b0;
        tick();
        check("release_loads_11", obs_reg(), ROW_11);

        // Combinational instance: clock stopped, rst high
        for (int i = 0; i < 4; i++) begin
            {a_c, b_c} = sw_ab[i];
            #1;
            check($sformatf("comb_row_%0d", i), obs_comb(), sw_ex[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_level.md
GATE_LEVEL -- requirements
Module: gate_level

Interface
REQ-001 Parameter REGISTER_OUTPUTS, default 1; 1 = outputs registered, 0 = outputs purely combinational (clk/rst unused).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a  input  1  first operand.
REQ-005 b  input  1  second operand.
REQ-006 and_out  output  1  a AND b.
REQ-007 or_out  output  1  a OR b.
REQ-008 notb_out  output  1  NOT b.
REQ-009 nand_out  output  1  NOT (a AND b).
REQ-010 nor_out  output  1  NOT (a OR b).
REQ-011 xor_out  output  1  a XOR b.
REQ-012 xnor_out  output  1  NOT (a XOR b).

Function
REQ-013 Logic functions SHALL be built from gate-level primitives (and, or, not, nand, nor, xor, xnor); no behavioural arithmetic.
REQ-014 With REGISTER_OUTPUTS=1, each output SHALL equal its function of a, b sampled at the most recent rising clk edge with rst low; latency exactly 1 cycle.
REQ-015 With REGISTER_OUTPUTS=1, outputs SHALL hold between edges regardless of mid-cycle a/b changes.
REQ-016 With REGISTER_OUTPUTS=0, outputs SHALL follow a, b combinationally, zero-cycle latency.
REQ-017 Truth table (a,b -> and,or,notb,nand,nor,xor,xnor): 00->0,0,1,1,1,0,1; 01->0,1,0,1,0,1,0; 10->0,1,1,1,0,1,0; 11->1,1,0,0,0,0,1.
REQ-018 X/Z on a or b SHALL NOT be masked; propagation follows primitive semantics.

Reset
REQ-019 With REGISTER_OUTPUTS=1, rst high at a rising edge SHALL force all seven outputs to 0 (including notb_out, nand_out, nor_out, xnor_out), overriding inputs.
REQ-020 Reset asserted mid-operation SHALL take effect at the next rising edge only; no asynchronous clearing.
REQ-021 First edge after rst deasserts SHALL load the function of current a, b.
REQ-022 With REGISTER_OUTPUTS=0, rst SHALL have no effect.

Structure
REQ-023 No shared package required; no typedefs or constants beyond REGISTER_OUTPUTS.
REQ-024 One sub-module, gate_level_bit_reg, SHALL implement a single 1-bit output stage: sync active-high reset to 0, bypassed when REGISTER_OUTPUTS=0; instantiated seven times.
REQ-025 Combinational gate network SHALL reside in gate_level itself.

Verification
REQ-026 REGISTER_OUTPUTS=1, rst=1 for 2 edges with a=1,b=1 -> all outputs 0.
REQ-027 Release rst, apply a,b = 00,01,10,11,00 for one cycle each (10 time units) -> after each edge outputs match REQ-017 rows, one cycle late.
REQ-028 a=1,b=0 held; toggle b mid-cycle and restore before edge -> outputs unchanged (and=0,or=1,notb=1,nand=1,nor=0,xor=1,xnor=0).
REQ-029 a=0,b=0 steady (xnor=1,nand=1), assert rst for one edge -> all outputs 0 that cycle, return to 00 row next edge after release.
REQ-030 REGISTER_OUTPUTS=0, sweep 00,01,10,11 with clk stopped and rst=1 -> outputs match REQ-017 immediately.
